// File: rtl/ifof_hazard_ctrl_pkg.sv
// simplerisc_pkg: shared SimpleRISC definitions for the IF/OF hazard controller
// and its source decoder.
//   - opcode constants
//   - instruction field bit positions
//   - return-address register number
//   - hazard controller state enum
//   - is_md_op() helper, which flags multi-cycle mul/div/mod opcodes
package simplerisc_pkg;

  localparam logic [4:0] OP_MUL  = 5'b00010;
  localparam logic [4:0] OP_DIV  = 5'b00011;
  localparam logic [4:0] OP_MOD  = 5'b00100;
  localparam logic [4:0] OP_ALU_LAST = 5'b01001;  // last opcode of the ALU/cmp group
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 27;
  localparam int IMM_BIT = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 22;
  localparam int RS1_MSB = 21;
  localparam int RS1_LSB = 18;
  localparam int RS2_MSB = 17;
  localparam int RS2_LSB = 14;

  localparam logic [3:0] RA_REG = 4'd15;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_BUSY = 2'd1,
    ST_HALT    = 2'd2
  } hz_state_e;

  function automatic logic is_md_op(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/ifof_hazard_ctrl_if.sv
// ifof_hazard_ctrl_if: bundle between the pipeline datapath and the hazard controller.
//   master modport (pipeline): drives the OF/EX status signals and receives the
//     stall, flush, bubble and hold controls.
//   slave modport (controller): the opposite direction.
//   CNT_W: width of the stall performance counter.
interface ifof_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      inst_of;
  logic             valid_of;
  logic             ex_valid;
  logic             ex_is_ld;
  logic [3:0]       ex_rd;
  logic             br_taken_ex;
  logic             mem_wait;
  logic             stall_pc;
  logic             stall_ifof;
  logic             flush_ifof;
  logic             bubble_ofex;
  logic             hold_ex;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output inst_of, valid_of, ex_valid, ex_is_ld, ex_rd, br_taken_ex, mem_wait,
    input  stall_pc, stall_ifof, flush_ifof, bubble_ofex, hold_ex, halted, stall_cycles
  );

  modport slave (
    input  inst_of, valid_of, ex_valid, ex_is_ld, ex_rd, br_taken_ex, mem_wait,
    output stall_pc, stall_ifof, flush_ifof, bubble_ofex, hold_ex, halted, stall_cycles
  );
endinterface

// File: rtl/ifof_src_decode.sv
// ifof_src_decode: combinational decode of the register sources read by an
// instruction. Shared with the forwarding unit.
//   inst_i          instruction word
//   src1_o/use1_o   rs1, or r15 for ret
//   src2_o/use2_o   rs2 (register form of ALU/cmp ops only)
//   src3_o/use3_o   rd, read as store data by st
module ifof_src_decode
  import simplerisc_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic [3:0]  src1_o,
  output logic        use1_o,
  output logic [3:0]  src2_o,
  output logic        use2_o,
  output logic [3:0]  src3_o,
  output logic        use3_o
);

  logic [4:0] op;
  logic       is_alu;
  logic       unused_imm_bits;

  assign op     = inst_i[OP_MSB:OP_LSB];
  assign is_alu = (op <= OP_ALU_LAST);

  // ret has no rs1 field: it reads the return address register instead.
  assign src1_o = (op == OP_RET) ? RA_REG : inst_i[RS1_MSB:RS1_LSB];
  assign use1_o = is_alu | (op == OP_LD) | (op == OP_ST) | (op == OP_RET);

  assign src2_o = inst_i[RS2_MSB:RS2_LSB];
  assign use2_o = is_alu & ~inst_i[IMM_BIT];

  assign src3_o = inst_i[RD_MSB:RD_LSB];
  assign use3_o = (op == OP_ST);

  assign unused_imm_bits = ^inst_i[13:0];

endmodule

// File: rtl/ifof_hazard_ctrl.sv
// ifof_hazard_ctrl: pipeline sequencing controller for the SimpleRISC 5-stage core.
// It compares the instruction in IF/OF with the instruction in EX and drives the
// PC, IF/OF, OF/EX and EX stall, flush and bubble controls.
//   clk, rst   core clock; asynchronous active-high reset
//   hz         slave side of ifof_hazard_ctrl_if
//                inputs:  OF/EX status, branch resolution, mem_wait
//                outputs: controls, halted, stall_cycles
//   MD_LAT     EX occupancy of mul/div/mod in cycles (2..15)
//   CNT_W      width of the stall performance counter
//   OP_HLT     opcode that halts the core
//
// state   | meaning
// RUN     | normal flow; resolves mem_wait, branch, load-use, halt, md issue
// MD_BUSY | mul/div/mod occupying EX; front end and EX held until md_cnt expires
// HALT    | core stopped; left only through rst
module ifof_hazard_ctrl
  import simplerisc_pkg::*;
#(
  parameter int         MD_LAT = 4,
  parameter int         CNT_W  = 16,
  parameter logic [4:0] OP_HLT = 5'b11111
)(
  input logic clk,
  input logic rst,
  ifof_hazard_ctrl_if.slave hz
);

  hz_state_e        state_q, state_d;
  logic [3:0]       md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] src1, src2, src3;
  logic       use1, use2, use3;
  logic [4:0] op_of;
  logic       load_use, is_md, is_hlt;
  logic       stall_pc, stall_ifof, flush_ifof, bubble_ofex, hold_ex, halted;

  ifof_src_decode u_src_decode (
    .inst_i (hz.inst_of),
    .src1_o (src1),
    .use1_o (use1),
    .src2_o (src2),
    .use2_o (use2),
    .src3_o (src3),
    .use3_o (use3)
  );

  assign op_of    = hz.inst_of[OP_MSB:OP_LSB];
  assign load_use = hz.valid_of & hz.ex_valid & hz.ex_is_ld &
                    ((use1 & (src1 == hz.ex_rd)) |
                     (use2 & (src2 == hz.ex_rd)) |
                     (use3 & (src3 == hz.ex_rd)));
  assign is_md    = hz.valid_of & is_md_op(op_of);
  assign is_hlt   = hz.valid_of & (op_of == OP_HLT);

  always_comb begin
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    stall_pc    = 1'b0;
    stall_ifof  = 1'b0;
    flush_ifof  = 1'b0;
    bubble_ofex = 1'b0;
    hold_ex     = 1'b0;
    halted      = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (hz.mem_wait) begin
          stall_pc   = 1'b1;
          stall_ifof = 1'b1;
          hold_ex    = 1'b1;
        end else if (hz.br_taken_ex) begin
          // OF holds a wrong-path instruction, so its hazards are irrelevant.
          flush_ifof  = 1'b1;
          bubble_ofex = 1'b1;
        end else if (load_use) begin
          stall_pc    = 1'b1;
          stall_ifof  = 1'b1;
          bubble_ofex = 1'b1;
        end else if (is_hlt) begin
          stall_pc    = 1'b1;
          stall_ifof  = 1'b1;
          bubble_ofex = 1'b1;
          state_d     = ST_HALT;
        end else if (is_md) begin
          // The issue cycle itself counts toward the md op's EX occupancy.
          md_cnt_d = 4'(MD_LAT - 1);
          state_d  = ST_MD_BUSY;
        end
      end
      ST_MD_BUSY: begin
        stall_pc   = 1'b1;
        stall_ifof = 1'b1;
        hold_ex    = 1'b1;
        if (!hz.mem_wait) begin
          md_cnt_d = md_cnt_q - 4'd1;
          if (md_cnt_q == 4'd1) state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        halted      = 1'b1;
        stall_pc    = 1'b1;
        stall_ifof  = 1'b1;
        bubble_ofex = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase

    // Outputs are forced low combinationally while reset is asserted.
    if (rst) begin
      stall_pc    = 1'b0;
      stall_ifof  = 1'b0;
      flush_ifof  = 1'b0;
      bubble_ofex = 1'b0;
      hold_ex     = 1'b0;
      halted      = 1'b0;
    end
  end

  assign cnt_d = (stall_pc && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      md_cnt_q <= 4'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      cnt_q    <= cnt_d;
    end
  end

  assign hz.stall_pc     = stall_pc;
  assign hz.stall_ifof   = stall_ifof;
  assign hz.flush_ifof   = flush_ifof;
  assign hz.bubble_ofex  = bubble_ofex;
  assign hz.hold_ex      = hold_ex;
  assign hz.halted       = halted;
  assign hz.stall_cycles = cnt_q;

endmodule

// File: tb/tb_ifof_hazard_ctrl.sv
module tb_ifof_hazard_ctrl;
  localparam int MD_LAT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] inst_of;
  logic        valid_of, ex_valid, ex_is_ld, br_taken_ex, mem_wait;
  logic [3:0]  ex_rd;

  ifof_hazard_ctrl_if #(.CNT_W(16)) hz16();
  ifof_hazard_ctrl_if #(.CNT_W(4))  hz4();

  assign hz16.inst_of = inst_of;      assign hz4.inst_of = inst_of;
  assign hz16.valid_of = valid_of;    assign hz4.valid_of = valid_of;
  assign hz16.ex_valid = ex_valid;    assign hz4.ex_valid = ex_valid;
  assign hz16.ex_is_ld = ex_is_ld;    assign hz4.ex_is_ld = ex_is_ld;
  assign hz16.ex_rd = ex_rd;          assign hz4.ex_rd = ex_rd;
  assign hz16.br_taken_ex = br_taken_ex; assign hz4.br_taken_ex = br_taken_ex;
  assign hz16.mem_wait = mem_wait;    assign hz4.mem_wait = mem_wait;

  ifof_hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(16)) dut (.clk(clk), .rst(rst), .hz(hz16.slave));
  ifof_hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .hz(hz4.slave));

  // Reference model: halted flag, cycles the md op has spent in EX (0 = none), counters.
  bit m_halt;
  int m_occ;
  int m_cnt16, m_cnt4;
  int checks = 0, failures = 0;

  int ops_tab[18] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 13, 14, 15, 16, 17, 18, 19, 20};

  function automatic logic [31:0] mk(int op, int imm, int rd, int rs1, int rs2);
    return {op[4:0], imm[0], rd[3:0], rs1[3:0], rs2[3:0], 14'h0};
  endfunction

  function automatic bit reads_reg(logic [31:0] i, logic [3:0] r);
    int op = int'(i[31:27]);
    bit alu = (op <= 9);
    bit hit = 0;
    if ((alu || op == 14 || op == 15) && i[21:18] == r) hit = 1;
    if (alu && !i[26] && i[17:14] == r) hit = 1;
    if (op == 15 && i[25:22] == r) hit = 1;
    if (op == 20 && r == 4'd15) hit = 1;
    return hit;
  endfunction

  function automatic bit ref_lu();
    return valid_of && ex_valid && ex_is_ld && reads_reg(inst_of, ex_rd);
  endfunction

  // Expected controls: [5]halted [4]hold_ex [3]bubble_ofex [2]flush_ifof [1]stall_ifof [0]stall_pc
  function automatic logic [5:0] ref_ctrl();
    int op = int'(inst_of[31:27]);
    if (rst)                       return 6'b000000;
    if (m_halt)                    return 6'b101011;
    if (m_occ > 0)                 return 6'b010011;
    if (mem_wait)                  return 6'b010011;
    if (br_taken_ex)               return 6'b001100;
    if (ref_lu())                  return 6'b001011;
    if (valid_of && op == 31)      return 6'b001011;
    return 6'b000000;
  endfunction

  function automatic logic [5:0] obs_ctrl();
    return {hz16.halted, hz16.hold_ex, hz16.bubble_ofex, hz16.flush_ifof, hz16.stall_ifof, hz16.stall_pc};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(logic [5:0] e);
    int op = int'(inst_of[31:27]);
    if (rst) begin
      m_halt = 0; m_occ = 0; m_cnt16 = 0; m_cnt4 = 0;
      return;
    end
    if (e[0]) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    if (m_halt) begin
    end else if (m_occ > 0) begin
      if (!mem_wait) begin
        m_occ++;
        if (m_occ == MD_LAT) m_occ = 0;
      end
    end else if (!mem_wait && !br_taken_ex && !ref_lu()) begin
      if (valid_of && op == 31) m_halt = 1;
      else if (valid_of && (op == 2 || op == 3 || op == 4)) m_occ = 1;
    end
  endtask

  // Entered at posedge+1 with inputs set; returns at the next posedge+1.
  task automatic cycle(string tag);
    logic [5:0] e;
    #1;
    e = ref_ctrl();
    check({tag, "_ctrl"}, 32'(obs_ctrl()), 32'(e));
    check({tag, "_cnt16"}, 32'(hz16.stall_cycles), m_cnt16);
    check({tag, "_cnt4"}, 32'(hz4.stall_cycles), m_cnt4);
    @(posedge clk);
    model_edge(e);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_halt = 0; m_occ = 0; m_cnt16 = 0; m_cnt4 = 0;
    #1;
    check("rst_ctrl", 32'(obs_ctrl()), 32'(ref_ctrl()));
    check("rst_cnt16", 32'(hz16.stall_cycles), m_cnt16);
    check("rst_cnt4", 32'(hz4.stall_cycles), m_cnt4);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle();
    inst_of = mk(13, 0, 0, 0, 0); valid_of = 1'b1;
    ex_valid = 1'b0; ex_is_ld = 1'b0; ex_rd = 4'd0;
    br_taken_ex = 1'b0; mem_wait = 1'b0;
  endtask

  initial begin
    int busy;
    int halt_len;
    rst = 1'b0;
    idle();
    #1;
    do_reset();

    // Load-use on rs1: one stall cycle, then the load has left EX.
    ex_valid = 1; ex_is_ld = 1; ex_rd = 4'd3;
    inst_of = mk(0, 0, 5, 3, 4);
    #1 check("lu_stall_pc", 32'(hz16.stall_pc), 1);
    cycle("lu_stall");
    ex_valid = 0; ex_is_ld = 0;
    cycle("lu_clear");
    check("lu_cnt", 32'(hz16.stall_cycles), 1);

    // Immediate form: rs2 field equals ex_rd but must not be treated as a source.
    ex_valid = 1; ex_is_ld = 1; ex_rd = 4'd3;
    inst_of = mk(0, 1, 5, 6, 3);
    cycle("lu_imm");

    // st reads rd; ret reads r15.
    ex_rd = 4'd7; inst_of = mk(15, 1, 7, 1, 0);
    cycle("st_rd");
    ex_rd = 4'd15; inst_of = mk(20, 0, 0, 0, 0);
    cycle("ret_r15");
    ex_rd = 4'd14;
    cycle("ret_r14");
    idle();

    // Mul issue followed by three busy cycles.
    busy = 0;
    inst_of = mk(2, 0, 1, 2, 3);
    for (int i = 0; i < 6; i++) begin
      if (i == 1) inst_of = mk(13, 0, 0, 0, 0);
      #1 if (hz16.hold_ex) busy++;
      cycle("md");
    end
    check("md_busy_len", busy, MD_LAT - 1);

    // Same with mem_wait during the busy window: two frozen cycles add on.
    busy = 0;
    inst_of = mk(3, 0, 1, 2, 3);
    for (int i = 0; i < 8; i++) begin
      if (i == 1) inst_of = mk(13, 0, 0, 0, 0);
      mem_wait = (i == 2 || i == 3);
      #1 if (hz16.hold_ex) busy++;
      cycle("md_mw");
    end
    check("md_mw_busy_len", busy, MD_LAT - 1 + 2);
    idle();

    // Taken branch wins over load-use.
    ex_valid = 1; ex_is_ld = 1; ex_rd = 4'd3;
    inst_of = mk(0, 0, 5, 3, 4); br_taken_ex = 1;
    #1 check("br_stall_pc", 32'(hz16.stall_pc), 0);
    check("br_flush", 32'(hz16.flush_ifof), 1);
    cycle("br_lu");
    idle();
    cycle("br_after");

    // Halt, held for 20 cycles with noise on the ignored inputs.
    inst_of = mk(31, 0, 0, 0, 0);
    cycle("hlt_enter");
    for (int i = 0; i < 20; i++) begin
      br_taken_ex = 1'($urandom_range(0, 1));
      mem_wait = 1'($urandom_range(0, 1));
      inst_of = $urandom;
      cycle("halt");
    end
    check("halt_held", 32'(hz16.halted), 1);
    check("sat_cnt4", 32'(hz4.stall_cycles), 15);
    do_reset();
    check("halt_drop", 32'(hz16.halted), 0);
    idle();

    // Randomized traffic against the model, with occasional resets.
    halt_len = 0;
    for (int n = 0; n < 600; n++) begin
      int pick = $urandom_range(0, 99);
      int op = (pick < 2) ? 31 : ops_tab[$urandom_range(0, 17)];
      inst_of = mk(op, $urandom_range(0, 3) == 0 ? 1 : 0, $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3));
      valid_of = ($urandom_range(0, 7) != 0);
      ex_valid = ($urandom_range(0, 3) != 0);
      ex_is_ld = ($urandom_range(0, 1) != 0);
      ex_rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      br_taken_ex = ($urandom_range(0, 9) == 0);
      mem_wait = ($urandom_range(0, 9) == 0);
      if (m_halt) halt_len++;
      if (halt_len > 4 || $urandom_range(0, 99) == 0) begin
        halt_len = 0;
        do_reset();
      end else begin
        cycle("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
